// File: rtl/rle_pkg.sv
// Shared definitions for the RLE pixel/audio decoder: opcodes, instruction
// field layout and FSM state encoding.
package rle_pkg;

    localparam int INSTR_W = 18;
    localparam int OP_W    = 2;
    localparam int RUN_W   = 8;
    localparam int PAY_W   = 8;
    localparam int OP_LSB  = 16;
    localparam int RUN_LSB = 8;
    localparam int PAY_LSB = 0;

    typedef enum logic [1:0] {
        OP_PIXEL = 2'b00,
        OP_AUDIO = 2'b01,
        OP_STOP  = 2'b10,
        OP_NOP   = 2'b11
    } opcode_t;

    typedef struct packed {
        opcode_t          op;
        logic [RUN_W-1:0] run;
        logic [PAY_W-1:0] payload;
    } instr_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_NEED = 2'b01,
        ST_HALT = 2'b10
    } state_t;

endpackage

// File: rtl/rle_run_counter.sv
// Remaining-run counter: loads a run length, decrements once per delivered
// pixel and flags the zero / final-pixel conditions.
import rle_pkg::*;

module rle_run_counter (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [RUN_W-1:0] load_val,
    output logic             zero,
    output logic             last
);

    logic [RUN_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == {{(RUN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/rle_pixel_decoder.sv
// RLE instruction decoder driving RGB332 pixels, PWM audio samples and STOP.
// Optional audio path enabled by defining RLE_AUDIO_EN.
import rle_pkg::*;

module rle_pixel_decoder (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_shift,
    input  logic               pixel_req,
    input  logic               mixed_region,
    output logic [2:0]         red,
    output logic [2:0]         green,
    output logic [1:0]         blue,
    output logic [7:0]         pwm_sample,
    output logic               sample_strobe,
    output logic               stop_detected,
    output logic               underrun
);

    instr_t           head;
    state_t           state;
    logic [PAY_W-1:0] colour;
    logic             pop;
    logic             load_run;
    logic             dec_run;
    logic             cnt_zero;
    logic             cnt_last;

    assign head.op      = opcode_t'(instr[OP_LSB +: OP_W]);
    assign head.run     = instr[RUN_LSB +: RUN_W];
    assign head.payload = instr[PAY_LSB +: PAY_W];

`ifndef RLE_AUDIO_EN
    logic unused_mixed;
    assign unused_mixed = mixed_region;
`endif

    // PIXEL is only taken when a run is exhausted and a pixel is wanted now;
    // in NEED an AUDIO head is always drained so video never deadlocks.
    always_comb begin
        pop = 1'b0;
        if (!rst && instr_valid && (state != ST_HALT)) begin
            case (head.op)
                OP_PIXEL: pop = (state == ST_NEED) && pixel_req;
`ifdef RLE_AUDIO_EN
                OP_AUDIO: pop = mixed_region || !pixel_req || (state == ST_NEED);
`else
                OP_AUDIO: pop = 1'b1;
`endif
                default:  pop = 1'b1;
            endcase
        end
    end

    assign instr_shift = pop;
    assign load_run    = pop && (head.op == OP_PIXEL);
    assign dec_run     = (state == ST_RUN) && pixel_req;

    rle_run_counter u_run_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_run),
        .dec      (dec_run),
        .load_val (head.run),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (load_run) begin
            colour <= head.payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_NEED;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            pwm_sample    <= 8'h80;
            sample_strobe <= 1'b0;
            stop_detected <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            stop_detected      <= pop && (head.op == OP_STOP);
            {red, green, blue} <= 8'h00;
            case (state)
                ST_RUN: begin
                    if (pixel_req) begin
                        {red, green, blue} <= colour;
                        if (cnt_last || cnt_zero) begin
                            state <= ST_NEED;
                        end
                    end
                end
                ST_NEED: begin
                    if (pixel_req) begin
                        if (load_run) begin
                            {red, green, blue} <= head.payload;
                            if (head.run != '0) begin
                                state <= ST_RUN;
                            end
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (pop && (head.op == OP_STOP)) begin
                state <= ST_HALT;
            end
`ifdef RLE_AUDIO_EN
            sample_strobe <= pop && (head.op == OP_AUDIO);
            if (pop && (head.op == OP_AUDIO)) begin
                pwm_sample <= head.payload;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rle_pixel_decoder.sv
// Self-checking bench for rle_pixel_decoder: vector tables with a scoreboard
// queue of registered-output expectations, plus a mid-run reset sequence.
module tb_rle_pixel_decoder;

`ifdef RLE_AUDIO_EN
    localparam bit AUD = 1'b1;
`else
    localparam bit AUD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_shift;
    logic        pixel_req = 1'b0;
    logic        mixed_region = 1'b0;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic [7:0]  pwm_sample;
    logic        sample_strobe;
    logic        stop_detected;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [17:0] instr;
        logic        valid;
        logic        preq;
        logic        mixed;
        logic        shift;
        logic [7:0]  rgb;
        logic [7:0]  pwm;
        logic        strobe;
        logic        stop;
        logic        urun;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    rle_pixel_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_shift   (instr_shift),
        .pixel_req     (pixel_req),
        .mixed_region  (mixed_region),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .pwm_sample    (pwm_sample),
        .sample_strobe (sample_strobe),
        .stop_detected (stop_detected),
        .underrun      (underrun)
    );

    always #20 clk = ~clk;

    function automatic logic [17:0] ins(input logic [1:0] op, input logic [7:0] run,
                                        input logic [7:0] pay);
        return {op, run, pay};
    endfunction

    function automatic vec_t mkv(input logic [17:0] i, input logic v, input logic p,
                                 input logic m, input logic sh, input logic [7:0] rgb,
                                 input logic [7:0] pwm, input logic stb, input logic stp,
                                 input logic ur);
        vec_t r;
        r.instr = i; r.valid = v; r.preq = p; r.mixed = m; r.shift = sh;
        r.rgb = rgb; r.pwm = pwm; r.strobe = stb; r.stop = stp; r.urun = ur;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; instr = '0; instr_valid = 1'b0; pixel_req = 1'b0; mixed_region = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called at posedge+1: drive one cycle, check the pop request before the
    // edge, then check the registered outputs that edge produced.
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        instr = v.instr; instr_valid = v.valid; pixel_req = v.preq; mixed_region = v.mixed;
        @(negedge clk);
        chk({tag, " shift"}, {7'd0, instr_shift}, {7'd0, v.shift});
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, " rgb"}, {red, green, blue}, e.rgb);
        chk({tag, " pwm"}, pwm_sample, e.pwm);
        chk({tag, " strobe"}, {7'd0, sample_strobe}, {7'd0, e.strobe});
        chk({tag, " stop"}, {7'd0, stop_detected}, {7'd0, e.stop});
        if (e.urun !== 1'bx) chk({tag, " underrun"}, {7'd0, underrun}, {7'd0, e.urun});
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vecs.size(); i++) apply($sformatf("%s[%0d]", name, i), vecs[i]);
        vecs.delete();
    endtask

    initial begin
        logic [17:0] px1c;
        logic [17:0] px55;
        logic [17:0] px49;
        logic [7:0]  p5a;

        // Reset state with a poppable instruction presented
        instr = ins(2'b11, 8'h00, 8'h00); instr_valid = 1'b1;
        @(negedge clk);
        chk("reset shift", {7'd0, instr_shift}, 8'h00);
        chk("reset rgb", {red, green, blue}, 8'h00);
        chk("reset pwm", pwm_sample, 8'h80);
        chk("reset flags", {5'd0, sample_strobe, stop_detected, underrun}, 8'h00);

        // Run of 4 red pixels, then single green, then underrun
        do_reset();
        px1c = ins(2'b00, 8'd0, 8'h1C);
        vecs.push_back(mkv(ins(2'b00, 8'd3, 8'hE0), 1, 1, 0, 1, 8'hE0, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(px1c, 1, 1, 0, 0, 8'hE0, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(px1c, 1, 1, 0, 0, 8'hE0, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(px1c, 1, 1, 0, 0, 8'hE0, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(px1c, 1, 1, 0, 1, 8'h1C, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(px1c, 0, 1, 0, 0, 8'h00, 8'h80, 0, 0, 1));
        vecs.push_back(mkv(px1c, 0, 1, 0, 0, 8'h00, 8'h80, 0, 0, 1));
        vecs.push_back(mkv(px1c, 0, 0, 0, 0, 8'h00, 8'h80, 0, 0, 1));
        run_table("run4");

        // Back-to-back single pixels, blanking inside a run, NOP popped in RUN
        do_reset();
        px55 = ins(2'b00, 8'd0, 8'h55);
        vecs.push_back(mkv(ins(2'b00, 8'd0, 8'hE0), 1, 1, 0, 1, 8'hE0, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(ins(2'b00, 8'd0, 8'h1C), 1, 1, 0, 1, 8'h1C, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(ins(2'b00, 8'd0, 8'h03), 1, 1, 0, 1, 8'h03, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(ins(2'b00, 8'd2, 8'hFF), 1, 1, 0, 1, 8'hFF, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(ins(2'b11, 8'd9, 8'h77), 1, 0, 0, 1, 8'h00, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(px55, 1, 1, 0, 0, 8'hFF, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(px55, 1, 1, 0, 0, 8'hFF, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(px55, 1, 1, 0, 1, 8'h55, 8'h80, 0, 0, 0));
        run_table("b2b");

        // Audio: blanking pop, forced pop in NEED, held off during a run
        do_reset();
        p5a = AUD ? 8'h5A : 8'h80;
        vecs.push_back(mkv(ins(2'b01, 8'd0, 8'h3C), 1, 0, 1, 1, 8'h00, AUD ? 8'h3C : 8'h80, AUD, 0, 0));
        vecs.push_back(mkv(ins(2'b01, 8'd0, 8'h3C), 0, 0, 1, 0, 8'h00, AUD ? 8'h3C : 8'h80, 0, 0, 0));
        vecs.push_back(mkv(ins(2'b01, 8'd0, 8'h5A), 1, 1, 0, 1, 8'h00, p5a, AUD, 0, 1));
        vecs.push_back(mkv(ins(2'b00, 8'd1, 8'hC0), 1, 1, 0, 1, 8'hC0, p5a, 0, 0, 1));
        vecs.push_back(mkv(ins(2'b01, 8'd0, 8'h11), 1, 1, 0, !AUD, 8'hC0, p5a, 0, 0, 1));
        vecs.push_back(mkv(ins(2'b01, 8'd0, 8'h11), 1, 0, 1, 1, 8'h00, AUD ? 8'h11 : 8'h80, AUD, 0, 1));
        run_table("audio");

        // STOP: one-cycle pulse, then nothing is popped and video stays black
        do_reset();
        vecs.push_back(mkv(ins(2'b10, 8'd0, 8'h00), 1, 0, 0, 1, 8'h00, 8'h80, 0, 1, 0));
        vecs.push_back(mkv(ins(2'b00, 8'd0, 8'hFF), 1, 1, 0, 0, 8'h00, 8'h80, 0, 0, 1'bx));
        vecs.push_back(mkv(ins(2'b00, 8'd3, 8'hFF), 1, 1, 1, 0, 8'h00, 8'h80, 0, 0, 1'bx));
        vecs.push_back(mkv(ins(2'b11, 8'd0, 8'h00), 1, 0, 0, 0, 8'h00, 8'h80, 0, 0, 1'bx));
        run_table("stop");

        // Reset asserted mid-run with the counter at 5
        do_reset();
        px49 = ins(2'b00, 8'd0, 8'h49);
        apply("mrst a", mkv(px49, 0, 1, 0, 0, 8'h00, 8'h80, 0, 0, 1));
        apply("mrst b", mkv(ins(2'b00, 8'd7, 8'h92), 1, 1, 0, 1, 8'h92, 8'h80, 0, 0, 1));
        apply("mrst c", mkv(px49, 0, 1, 0, 0, 8'h92, 8'h80, 0, 0, 1));
        apply("mrst d", mkv(px49, 0, 1, 0, 0, 8'h92, 8'h80, 0, 0, 1));
        instr = px49; instr_valid = 1'b1; pixel_req = 1'b1;
        #5 rst = 1'b1;
        #1;
        chk("mrst async rgb", {red, green, blue}, 8'h00);
        chk("mrst async underrun", {7'd0, underrun}, 8'h00);
        chk("mrst async pwm", pwm_sample, 8'h80);
        chk("mrst async shift", {7'd0, instr_shift}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        apply("mrst e", mkv(px49, 1, 0, 0, 0, 8'h00, 8'h80, 0, 0, 0));
        apply("mrst f", mkv(px49, 1, 1, 0, 1, 8'h49, 8'h80, 0, 0, 0));
        apply("mrst g", mkv(px49, 0, 1, 0, 0, 8'h00, 8'h80, 0, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rle_pixel_decoder.md
RLE_PIXEL_DECODER -- requirements
Module: rle_pixel_decoder

Interface
REQ-001 SHALL have port clk, input, 1, single clock (~25 MHz pixel clock); all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port instr, input, 18, instruction at head of the buffer chain; [17:16] opcode, [15:8] run field, [7:0] payload.
REQ-004 SHALL have port instr_valid, input, 1, head buffer holds a valid instruction.
REQ-005 SHALL have port instr_shift, output, 1, combinational pop request; head consumed at this clock edge.
REQ-006 SHALL have port pixel_req, input, 1, VGA timing requests one pixel this cycle (active video).
REQ-007 SHALL have port mixed_region, input, 1, blanking window where audio consumption is permitted.
REQ-008 SHALL have ports red, green and blue, output, 3/3/2, registered RGB332 colour.
REQ-009 SHALL have port pwm_sample, output, 8, last accepted audio sample, registered.
REQ-010 SHALL have port sample_strobe, output, 1, one-cycle pulse when pwm_sample updates.
REQ-011 SHALL have port stop_detected, output, 1, one-cycle pulse on STOP opcode.
REQ-012 SHALL have port underrun, output, 1, sticky; set when a pixel is needed and none is available.

Function
REQ-013 SHALL decode opcodes: 00 PIXEL (run = [15:8]+1 pixels, colour = [7:0] as R[7:5] G[4:2] B[1:0]); 01 AUDIO (sample = [7:0]); 10 STOP; 11 NOP.
REQ-014 SHALL implement states RUN, NEED, HALT; leave reset in NEED.
REQ-015 SHALL, in RUN, decrement the 8-bit remaining-run counter on each pixel_req, re-driving the current colour; at counter 0 with pixel_req, go to NEED after that pixel.
REQ-016 SHALL, in NEED with pixel_req, instr_valid and opcode PIXEL, assert instr_shift, load the colour into the output registers (visible the next cycle), load counter = run field, and go to RUN if run field > 0, else stay in NEED.
REQ-017 SHALL, in NEED with pixel_req and no valid PIXEL at head, output black for that pixel and set underrun; state unchanged.
REQ-018 SHALL pop AUDIO when at head with instr_valid and (mixed_region or not pixel_req); latch pwm_sample and pulse sample_strobe the next cycle.
REQ-019 SHALL, when AUDIO is at head with pixel_req high in NEED outside mixed_region, pop it, output black and set underrun (no deadlock).
REQ-020 SHALL pop NOP whenever it is at head with instr_valid; no other effect.
REQ-021 SHALL, on STOP at head with instr_valid, pop it, pulse stop_detected for one cycle and enter HALT; HALT pops nothing and outputs black until reset.
REQ-022 SHALL drive RGB = 0 in any cycle following one where pixel_req was low (blanking).
REQ-023 SHALL never assert instr_shift without instr_valid; at most one pop per cycle.
REQ-024 SHALL treat pixel_req without prefetch: one PIXEL instruction loaded per exhausted run; back-to-back single-pixel runs pop every cycle.

Reset
REQ-025 SHALL, on rst, asynchronously clear the following: RGB=0, pwm_sample=0x80, sample_strobe=0, stop_detected=0, underrun=0, counter=0, state=NEED; instr_shift=0 while rst is high.
REQ-026 SHALL discard any run in progress when reset is asserted mid-run; no pop occurs in the first cycle after deassertion unless the conditions in the Function requirements hold.

Configuration
REQ-027 SHALL use macro RLE_AUDIO_EN: when defined, AUDIO behaves per REQ-018 and REQ-019; when undefined, AUDIO is treated as NOP, pwm_sample is held at 0x80 and sample_strobe is held at 0.

Structure
REQ-028 SHALL place opcode constants, field widths/offsets, the 18-bit instruction typedef and the HALT/RUN/NEED state encoding in shared package rle_pkg.
REQ-029 SHALL factor the run counter (load, decrement, zero flag) into sub-module rle_run_counter.

Verification
REQ-030 SHALL cover: PIXEL run=3 colour 0xE0, pixel_req held -> one pop, red=7 for 4 pixel cycles, then a pop on the 5th request.
REQ-031 SHALL cover: instr_valid=0 in NEED with pixel_req -> RGB=0, underrun=1 and stays 1, instr_shift=0.
REQ-032 SHALL cover: AUDIO 0x3C during mixed_region, pixel_req=0 -> pop, pwm_sample=0x3C, sample_strobe high exactly one cycle (and held at 0x80 with no strobe when RLE_AUDIO_EN is undefined).
REQ-033 SHALL cover: STOP at head -> stop_detected one cycle, HALT, later PIXELs never popped, RGB=0.
REQ-034 SHALL cover: three consecutive PIXEL run=0 entries -> pop each cycle, colours change each cycle.
REQ-035 SHALL cover: rst pulsed mid-run (counter=5) -> outputs at reset values immediately, NEED state, next PIXEL loads cleanly.
